// File: rtl/revo_phase_tracker.sv
// rtl/revo_phase_tracker.sv - revo rising-edge phase picker with periodic confirmation, lock tracking and holdover
// Emits one revo_out per period slot while locked or in holdover, synthesising pulses for missing revos.
module revo_phase_tracker #(
  parameter int WIDTH         = 4,
  parameter int PERIOD_WORDS  = 1280,
  parameter int CONFIRM_COUNT = 3,
  parameter int MISS_LIMIT    = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [WIDTH-1:0]                 word_in,
  output logic [$clog2(WIDTH)-1:0]         phase,
  output logic                             locked,
  output logic                             holdover,
  output logic                             revo_out,
  output logic                             revo_is_fake,
  output logic                             mismatch,
  output logic [$clog2(MISS_LIMIT+1)-1:0]  miss_count,
  output logic [1:0]                       state
);

  localparam int PW = $clog2(WIDTH);
  localparam int CW = $clog2(PERIOD_WORDS);
  localparam int FW = $clog2(CONFIRM_COUNT + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);

  localparam logic [CW-1:0] SLOT_COUNT   = CW'(PERIOD_WORDS - 1);
  localparam logic [FW-1:0] CONFIRM_LAST = FW'(CONFIRM_COUNT - 1);
  localparam logic [MW-1:0] MISS_LAST    = MW'(MISS_LIMIT - 1);
  localparam logic [MW-1:0] MISS_FULL    = MW'(MISS_LIMIT);

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    CONFIRM  = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } state_t;

  state_t          fsm;
  logic            prev_lsb;
  logic [WIDTH:0]  samples;
  logic            raw_valid;
  logic [PW-1:0]   raw_pos;
  logic            edge_valid;
  logic [PW-1:0]   edge_pos;
  logic [CW-1:0]   period_cnt;
  logic [CW-1:0]   period_next;
  logic            slot;
  logic [PW-1:0]   candidate;
  logic [FW-1:0]   confirm;

  assign state = fsm;

  // samples[p] is the sample preceding position p; position 0 is preceded by the last word's bit 0
  assign samples = {word_in, prev_lsb};

  always_comb begin
    raw_valid = 1'b0;
    raw_pos   = '0;
    for (int p = WIDTH - 1; p >= 0; p--) begin
      if (samples[p+1] && !samples[p]) begin
        raw_valid = 1'b1;
        raw_pos   = PW'(p);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_lsb   <= 1'b0;
      edge_valid <= 1'b0;
      edge_pos   <= '0;
    end else begin
      prev_lsb   <= word_in[0];
      edge_valid <= raw_valid;
      edge_pos   <= raw_pos;
    end
  end

  assign slot        = (period_cnt == SLOT_COUNT);
  assign period_next = slot ? '0 : period_cnt + CW'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm          <= SEARCH;
      period_cnt   <= '0;
      candidate    <= '0;
      confirm      <= '0;
      phase        <= '0;
      locked       <= 1'b0;
      holdover     <= 1'b0;
      revo_out     <= 1'b0;
      revo_is_fake <= 1'b0;
      mismatch     <= 1'b0;
      miss_count   <= '0;
    end else begin
      revo_out     <= 1'b0;
      revo_is_fake <= 1'b0;
      mismatch     <= 1'b0;
      period_cnt   <= period_next;

      case (fsm)
        SEARCH: begin
          if (edge_valid) begin
            candidate  <= edge_pos;
            confirm    <= FW'(1);
            period_cnt <= '0;
            fsm        <= CONFIRM;
          end
        end

        CONFIRM: begin
          if (edge_valid && slot && edge_pos == candidate) begin
            confirm <= confirm + FW'(1);
            if (confirm == CONFIRM_LAST) begin
              phase      <= candidate;
              miss_count <= '0;
              locked     <= 1'b1;
              fsm        <= LOCKED;
            end
          end else if (edge_valid) begin
            candidate  <= edge_pos;
            confirm    <= FW'(1);
            period_cnt <= '0;
          end else if (slot) begin
            fsm <= SEARCH;
          end
        end

        LOCKED: begin
          // a matching edge on the slot wins over the miss accounting for that slot
          if (edge_valid && slot && edge_pos == phase) begin
            revo_out   <= 1'b1;
            miss_count <= '0;
          end else begin
            if (edge_valid) begin
              mismatch <= 1'b1;
            end
            if (slot) begin
              revo_out     <= 1'b1;
              revo_is_fake <= 1'b1;
              if (miss_count == MISS_LAST) begin
                miss_count <= MISS_FULL;
                locked     <= 1'b0;
                holdover   <= 1'b1;
                fsm        <= HOLDOVER;
              end else begin
                miss_count <= miss_count + MW'(1);
              end
            end
          end
        end

        HOLDOVER: begin
          if (edge_valid) begin
            candidate  <= edge_pos;
            confirm    <= FW'(1);
            period_cnt <= '0;
            holdover   <= 1'b0;
            fsm        <= CONFIRM;
          end else if (slot) begin
            revo_out     <= 1'b1;
            revo_is_fake <= 1'b1;
          end
        end

        default: fsm <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_revo_phase_tracker.sv
// tb/tb_revo_phase_tracker.sv - scoreboard bench for revo_phase_tracker
// A word-indexed reference model queues expected outputs two clocks ahead of the DUT.
module tb_revo_phase_tracker;

  localparam int PER = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] word_in = 4'b0000;
  logic [1:0] phase;
  logic       locked;
  logic       holdover;
  logic       revo_out;
  logic       revo_is_fake;
  logic       mismatch;
  logic [1:0] miss_count;
  logic [1:0] state;

  revo_phase_tracker #(
    .WIDTH(4),
    .PERIOD_WORDS(PER),
    .CONFIRM_COUNT(3),
    .MISS_LIMIT(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .word_in(word_in),
    .phase(phase),
    .locked(locked),
    .holdover(holdover),
    .revo_out(revo_out),
    .revo_is_fake(revo_is_fake),
    .mismatch(mismatch),
    .miss_count(miss_count),
    .state(state)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int when;
    int revo;
    int fake;
    int mism;
    int lck;
    int hold;
    int st;
    int ph;
    int mc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  // reference model state, indexed by absolute word number
  int   m_n, m_state, m_cand, m_phase, m_conf, m_miss, m_due;
  logic m_prev;

  task automatic model_reset();
    m_n = 0; m_state = 0; m_cand = 0; m_phase = 0;
    m_conf = 0; m_miss = 0; m_due = -1; m_prev = 1'b0;
  endtask

  task automatic model_seed(input int pos);
    m_cand  = pos;
    m_conf  = 1;
    m_due   = m_n + PER;
    m_state = 1;
  endtask

  task automatic model_word(input logic [3:0] w);
    logic [4:0] s;
    int   e_valid, e_pos, at_slot;
    exp_t e;
    s = {w, m_prev};
    e_valid = 0;
    e_pos = 0;
    for (int p = 0; p < 4; p++) begin
      if (e_valid == 0 && w[p] && !s[p]) begin
        e_valid = 1;
        e_pos = p;
      end
    end
    m_prev = w[0];
    at_slot = (m_n == m_due) ? 1 : 0;
    e.revo = 0; e.fake = 0; e.mism = 0;
    case (m_state)
      0: if (e_valid != 0) model_seed(e_pos);
      1: begin
        if (e_valid != 0 && at_slot != 0 && e_pos == m_cand) begin
          m_conf++;
          m_due += PER;
          if (m_conf == 3) begin
            m_state = 2;
            m_phase = m_cand;
            m_miss = 0;
          end
        end else if (e_valid != 0) begin
          model_seed(e_pos);
        end else if (at_slot != 0) begin
          m_state = 0;
        end
      end
      2: begin
        if (at_slot != 0) m_due += PER;
        if (e_valid != 0 && at_slot != 0 && e_pos == m_phase) begin
          e.revo = 1;
          m_miss = 0;
        end else begin
          if (e_valid != 0) e.mism = 1;
          if (at_slot != 0) begin
            e.revo = 1;
            e.fake = 1;
            m_miss++;
            if (m_miss == 2) m_state = 3;
          end
        end
      end
      default: begin
        if (e_valid != 0) begin
          model_seed(e_pos);
        end else if (at_slot != 0) begin
          e.revo = 1;
          e.fake = 1;
          m_due += PER;
        end
      end
    endcase
    m_n++;
    e.when = cyc + 2;
    e.lck  = (m_state == 2) ? 1 : 0;
    e.hold = (m_state == 3) ? 1 : 0;
    e.st   = m_state;
    e.ph   = m_phase;
    e.mc   = m_miss;
    sbq.push_back(e);
  endtask

  always @(negedge clock) begin
    if (sbq.size() > 0 && sbq[0].when == cyc) begin
      mon_e = sbq.pop_front();
      check_eq("revo_out",     int'(revo_out),     mon_e.revo);
      check_eq("revo_is_fake", int'(revo_is_fake), mon_e.fake);
      check_eq("mismatch",     int'(mismatch),     mon_e.mism);
      check_eq("state",        int'(state),        mon_e.st);
      check_eq("locked",       int'(locked),       mon_e.lck);
      check_eq("holdover",     int'(holdover),     mon_e.hold);
      check_eq("phase",        int'(phase),        mon_e.ph);
      check_eq("miss_count",   int'(miss_count),   mon_e.mc);
    end
  end

  task automatic step(input logic [3:0] w);
    word_in = w;
    model_word(w);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000);
  endtask

  task automatic pulse_train(input logic [3:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      step(w);
      idle(PER - 1);
    end
  endtask

  // asserts reset between clock edges and checks the outputs clear before any edge arrives
  task automatic do_reset(input string tag);
    reset = 1'b1;
    word_in = 4'b0000;
    sbq.delete();
    model_reset();
    #2;
    check_eq({tag, "_phase"},    int'(phase),        0);
    check_eq({tag, "_locked"},   int'(locked),       0);
    check_eq({tag, "_holdover"}, int'(holdover),     0);
    check_eq({tag, "_revo"},     int'(revo_out),     0);
    check_eq({tag, "_fake"},     int'(revo_is_fake), 0);
    check_eq({tag, "_mism"},     int'(mismatch),     0);
    check_eq({tag, "_miss"},     int'(miss_count),   0);
    check_eq({tag, "_state"},    int'(state),        0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clock);
    #1;
    do_reset("rst0");

    // lock on 1100, then one real revo
    idle(3);
    pulse_train(4'b1100, 3);
    check_eq("s1_locked", int'(locked), 1);
    check_eq("s1_phase",  int'(phase),  2);
    pulse_train(4'b1100, 1);

    // one missing revo, then recovery
    idle(PER);
    check_eq("s3_miss",   int'(miss_count), 1);
    check_eq("s3_locked", int'(locked),     1);
    pulse_train(4'b1100, 1);
    check_eq("s3_clear",  int'(miss_count), 0);

    // two missing revos -> holdover, then an edge re-seeds, then the slot lapses
    idle(2 * PER);
    check_eq("s4_hold",   int'(holdover), 1);
    check_eq("s4_locked", int'(locked),   0);
    check_eq("s4_state",  int'(state),    3);
    idle(2 * PER);
    idle(5);
    pulse_train(4'b1100, 1);
    check_eq("s4_confirm",  int'(state),    1);
    check_eq("s4_hold_off", int'(holdover), 0);
    idle(20);
    check_eq("s4_search", int'(state), 0);

    // on-slot wrong-phase edge during confirm re-seeds the candidate
    do_reset("rst1");
    idle(3);
    pulse_train(4'b1100, 1);
    pulse_train(4'b1110, 1);
    check_eq("s2_state", int'(state), 1);
    pulse_train(4'b1110, 1);
    check_eq("s2_not_yet", int'(locked), 0);
    pulse_train(4'b1110, 1);
    check_eq("s2_locked", int'(locked), 1);
    check_eq("s2_phase",  int'(phase),  1);

    // reset while locked, fresh lock needs three edges
    idle(4);
    do_reset("rst_mid");
    idle(2);
    pulse_train(4'b1110, 2);
    check_eq("s6_state",  int'(state),  1);
    check_eq("s6_locked", int'(locked), 0);
    pulse_train(4'b1110, 1);
    check_eq("s6_relock", int'(locked), 1);

    // 1111 after a 0 LSB is phase 0; 1111 after a 1 LSB has no edge; off-slot 1010 mismatches
    do_reset("rst2");
    idle(2);
    pulse_train(4'b1111, 3);
    check_eq("s5_phase0", int'(phase),  0);
    check_eq("s5_locked", int'(locked), 1);
    step(4'b1111);
    for (int i = 0; i < 3; i++) step(4'b1111);
    idle(PER - 4);
    step(4'b1111);
    idle(5);
    step(4'b1010);
    idle(PER - 7);
    step(4'b1111);
    idle(PER - 1);
    check_eq("s5_phase_held", int'(phase),      0);
    check_eq("s5_still_lock", int'(locked),     1);
    check_eq("s5_miss",       int'(miss_count), 0);

    // 1010 after 0000: lowest edge position is 1
    do_reset("rst3");
    idle(2);
    pulse_train(4'b1010, 3);
    check_eq("s5_1010_phase",  int'(phase),  1);
    check_eq("s5_1010_locked", int'(locked), 1);

    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    check_eq("sb_drain", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
